// File: rtl/rc4_pkg.sv
// ============================================================================
// Module      : rc4_pkg
// Description : Shared types and constants for the RC4 phase sequencer:
//               sequencer state encoding, S-RAM phase owner IDs and the
//               S-RAM geometry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rc4_pkg;

    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_GAP1  = 3'd2,
        ST_SHUF  = 3'd3,
        ST_GAP2  = 3'd4,
        ST_DEC   = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERROR = 3'd7
    } phase_state_e;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_INIT = 2'd1,
        PH_SHUF = 2'd2,
        PH_DEC  = 2'd3
    } phase_id_e;

    // Maps a sequencer state to the phase that owns the S RAM in it.
    // Gaps, IDLE, DONE and ERROR own nothing.
    function automatic phase_id_e owner_of(input phase_state_e s);
        phase_id_e r;
        case (s)
            ST_INIT: r = PH_INIT;
            ST_SHUF: r = PH_SHUF;
            ST_DEC:  r = PH_DEC;
            default: r = PH_NONE;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/s_mem_mux.sv
// ============================================================================
// Module      : s_mem_mux
// Description : 3-way S-RAM request multiplexer. Forwards the selected
//               phase's address/data/write-enable combinationally and drives
//               all zeros when no phase owns the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module s_mem_mux
    import rc4_pkg::*;
#(
    parameter int ADDR_W = S_ADDR_W,
    parameter int DATA_W = S_DATA_W
) (
    input  phase_id_e           i_sel,
    input  logic [ADDR_W-1:0]   i_init_addr,
    input  logic [DATA_W-1:0]   i_init_data,
    input  logic                i_init_wren,
    input  logic [ADDR_W-1:0]   i_shuf_addr,
    input  logic [DATA_W-1:0]   i_shuf_data,
    input  logic                i_shuf_wren,
    input  logic [ADDR_W-1:0]   i_dec_addr,
    input  logic [DATA_W-1:0]   i_dec_data,
    input  logic                i_dec_wren,
    output logic [ADDR_W-1:0]   o_addr,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_wren
);

    // Zero-latency select; a non-owner can never reach the RAM.
    always_comb begin
        o_addr = '0;
        o_data = '0;
        o_wren = 1'b0;
        case (i_sel)
            PH_INIT: begin
                o_addr = i_init_addr;
                o_data = i_init_data;
                o_wren = i_init_wren;
            end
            PH_SHUF: begin
                o_addr = i_shuf_addr;
                o_data = i_shuf_data;
                o_wren = i_shuf_wren;
            end
            PH_DEC: begin
                o_addr = i_dec_addr;
                o_data = i_dec_data;
                o_wren = i_dec_wren;
            end
            default: begin
                o_addr = '0;
                o_data = '0;
                o_wren = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rc4_phase_sequencer.sv
// ============================================================================
// Module      : rc4_phase_sequencer
// Description : Top-level RC4 controller. Runs init fill, key-schedule
//               shuffle and decrypt in order with level start / done
//               handshakes, grants the single-port S RAM to the active
//               phase only, and watchdogs every phase for hangs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rc4_phase_sequencer
    import rc4_pkg::*;
#(
    parameter int ADDR_W   = S_ADDR_W,
    parameter int DATA_W   = S_DATA_W,
    parameter int TIMEOUT  = 4096,
    parameter int MASK_CYC = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                go,
    output logic                busy,
    output logic                all_done,
    output logic                error,
    output logic [1:0]          err_phase,
    output logic                init_start,
    output logic                shuf_start,
    output logic                dec_start,
    input  logic                init_done,
    input  logic                shuf_done,
    input  logic                dec_done,
    input  logic [ADDR_W-1:0]   init_addr,
    input  logic [DATA_W-1:0]   init_data,
    input  logic                init_wren,
    input  logic [ADDR_W-1:0]   shuf_addr,
    input  logic [DATA_W-1:0]   shuf_data,
    input  logic                shuf_wren,
    input  logic [ADDR_W-1:0]   dec_addr,
    input  logic [DATA_W-1:0]   dec_data,
    input  logic                dec_wren,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_data,
    output logic                mem_wren
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_MASK = CNT_W'(MASK_CYC);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_SAT  = '1;

    phase_state_e       r_state;
    phase_state_e       w_next;
    phase_id_e          w_err_ph;
    phase_id_e          r_err_phase;
    phase_id_e          w_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_done_ok;
    logic               w_last;
    logic               r_busy;
    logic               r_all_done;
    logic               r_error;
    logic               r_init_start;
    logic               r_shuf_start;
    logic               r_dec_start;

    // Next-state logic: done beats timeout when both land in one cycle.
    always_comb begin
        w_next    = r_state;
        w_err_ph  = PH_NONE;
        w_done_ok = (r_cnt >= C_MASK);
        w_last    = (r_cnt == C_LAST);
        case (r_state)
            ST_IDLE: begin
                if (go) w_next = ST_INIT;
            end
            ST_INIT: begin
                if (w_done_ok && init_done) begin
                    w_next = ST_GAP1;
                end else if (w_last) begin
                    w_next   = ST_ERROR;
                    w_err_ph = PH_INIT;
                end
            end
            ST_GAP1: w_next = ST_SHUF;
            ST_SHUF: begin
                if (w_done_ok && shuf_done) begin
                    w_next = ST_GAP2;
                end else if (w_last) begin
                    w_next   = ST_ERROR;
                    w_err_ph = PH_SHUF;
                end
            end
            ST_GAP2: w_next = ST_DEC;
            ST_DEC: begin
                if (w_done_ok && dec_done) begin
                    w_next = ST_DONE;
                end else if (w_last) begin
                    w_next   = ST_ERROR;
                    w_err_ph = PH_DEC;
                end
            end
            ST_DONE: begin
                if (go) w_next = ST_INIT;
            end
            ST_ERROR: begin
                if (go) w_next = ST_INIT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register plus registered starts/status decoded from next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_all_done   <= 1'b0;
            r_error      <= 1'b0;
            r_init_start <= 1'b0;
            r_shuf_start <= 1'b0;
            r_dec_start  <= 1'b0;
            r_err_phase  <= PH_NONE;
        end else begin
            r_state      <= w_next;
            r_busy       <= (w_next == ST_INIT) || (w_next == ST_GAP1) ||
                            (w_next == ST_SHUF) || (w_next == ST_GAP2) ||
                            (w_next == ST_DEC);
            r_all_done   <= (w_next == ST_DONE);
            r_error      <= (w_next == ST_ERROR);
            r_init_start <= (w_next == ST_INIT);
            r_shuf_start <= (w_next == ST_SHUF);
            r_dec_start  <= (w_next == ST_DEC);
            if ((w_next == ST_ERROR) && (r_state != ST_ERROR)) begin
                r_err_phase <= w_err_ph;
            end else if ((r_state == ST_ERROR) && (w_next == ST_INIT)) begin
                r_err_phase <= PH_NONE;
            end
        end
    end

    // Per-phase watchdog counter: cleared on every state change, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (r_cnt != C_SAT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_owner    = owner_of(r_state);
    assign busy       = r_busy;
    assign all_done   = r_all_done;
    assign error      = r_error;
    assign err_phase  = r_err_phase;
    assign init_start = r_init_start;
    assign shuf_start = r_shuf_start;
    assign dec_start  = r_dec_start;

    s_mem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .i_sel       (w_owner),
        .i_init_addr (init_addr),
        .i_init_data (init_data),
        .i_init_wren (init_wren),
        .i_shuf_addr (shuf_addr),
        .i_shuf_data (shuf_data),
        .i_shuf_wren (shuf_wren),
        .i_dec_addr  (dec_addr),
        .i_dec_data  (dec_data),
        .i_dec_wren  (dec_wren),
        .o_addr      (mem_address),
        .o_data      (mem_data),
        .o_wren      (mem_wren)
    );

endmodule

`default_nettype wire

// File: tb/tb_rc4_phase_sequencer.sv
// ============================================================================
// Module      : tb_rc4_phase_sequencer
// Description : Directed self-checking bench for rc4_phase_sequencer. Two
//               instances share stimulus: one with the default watchdog and
//               one with TIMEOUT=64 for the hang scenario. Behavioural
//               engines answer the start levels; a small RAM model records
//               forwarded writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rc4_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       go;
    logic       init_done, shuf_done, dec_done;
    logic [7:0] init_addr, shuf_addr, dec_addr;
    logic [7:0] init_data, shuf_data, dec_data;
    logic       init_wren, shuf_wren, dec_wren;

    logic       busy, all_done, error, init_start, shuf_start, dec_start, mem_wren;
    logic [1:0] err_phase;
    logic [7:0] mem_address, mem_data;

    logic       t_busy, t_all_done, t_error, t_init_start, t_shuf_start, t_dec_start, t_mem_wren;
    logic [1:0] t_err_phase;
    logic [7:0] t_mem_address, t_mem_data;

    int n_cmp = 0;
    int n_err = 0;
    int multi = 0;

    // Engine controls
    logic use_t      = 1'b0;
    logic iso        = 1'b1;
    logic stale_hold = 1'b0;
    int   stale_len  = 0;
    int   init_d     = 257;
    int   shuf_d     = 768;
    int   dec_d      = 64;
    int   ik = 0, sk = 0, dk = 0;

    logic [7:0] ram [256];

    always #5 clk = ~clk;

    rc4_phase_sequencer dut (
        .clk(clk), .reset_n(reset_n), .go(go),
        .busy(busy), .all_done(all_done), .error(error), .err_phase(err_phase),
        .init_start(init_start), .shuf_start(shuf_start), .dec_start(dec_start),
        .init_done(init_done), .shuf_done(shuf_done), .dec_done(dec_done),
        .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
        .shuf_addr(shuf_addr), .shuf_data(shuf_data), .shuf_wren(shuf_wren),
        .dec_addr(dec_addr), .dec_data(dec_data), .dec_wren(dec_wren),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren)
    );

    rc4_phase_sequencer #(.TIMEOUT(64)) dut_t (
        .clk(clk), .reset_n(reset_n), .go(go),
        .busy(t_busy), .all_done(t_all_done), .error(t_error), .err_phase(t_err_phase),
        .init_start(t_init_start), .shuf_start(t_shuf_start), .dec_start(t_dec_start),
        .init_done(init_done), .shuf_done(shuf_done), .dec_done(dec_done),
        .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
        .shuf_addr(shuf_addr), .shuf_data(shuf_data), .shuf_wren(shuf_wren),
        .dec_addr(dec_addr), .dec_data(dec_data), .dec_wren(dec_wren),
        .mem_address(t_mem_address), .mem_data(t_mem_data), .mem_wren(t_mem_wren)
    );

    // S RAM model fed by the main instance
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Leaves the caller at tick 0: just after the edge that sampled go.
    task automatic pulse_go();
        go = 1'b1;
        tick(1);
        go = 1'b0;
    endtask

    // Behavioural phase engines, driven on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (use_t ? t_init_start : init_start) begin
                init_addr = (ik < 256) ? 8'(ik) : 8'h00;
                init_data = (ik < 256) ? 8'(ik) : 8'h00;
                init_wren = (ik < 256);
                init_done = (ik >= init_d - 1) || (ik < stale_len);
                ik++;
            end else begin
                ik = 0;
                init_addr = iso ? 8'h55 : 8'h00;
                init_data = iso ? 8'hAA : 8'h00;
                init_wren = iso;
                init_done = stale_hold;
            end
            if (use_t ? t_shuf_start : shuf_start) begin
                shuf_addr = 8'(sk) ^ 8'h3C;
                shuf_data = 8'(sk);
                shuf_wren = sk[0];
                shuf_done = (sk >= shuf_d - 1);
                sk++;
            end else begin
                sk = 0;
                shuf_addr = iso ? 8'h55 : 8'h00;
                shuf_data = iso ? 8'hAA : 8'h00;
                shuf_wren = iso;
                shuf_done = 1'b0;
            end
            if (use_t ? t_dec_start : dec_start) begin
                dec_addr = 8'(dk);
                dec_data = 8'h00;
                dec_wren = 1'b0;
                dec_done = (dk >= dec_d - 1);
                dk++;
            end else begin
                dk = 0;
                dec_addr = iso ? 8'h55 : 8'h00;
                dec_data = iso ? 8'hAA : 8'h00;
                dec_wren = iso;
                dec_done = 1'b0;
            end
        end
    end

    // Starts of the main instance must be one-hot-or-zero at all times.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if ((int'(init_start) + int'(shuf_start) + int'(dec_start)) > 1) multi++;
        end
    end

    initial begin
        int bad;
        reset_n   = 1'b0;
        go        = 1'b0;
        init_done = 1'b0; shuf_done = 1'b0; dec_done = 1'b0;
        init_addr = '0; shuf_addr = '0; dec_addr = '0;
        init_data = '0; shuf_data = '0; dec_data = '0;
        init_wren = 1'b0; shuf_wren = 1'b0; dec_wren = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 8'hFF;

        // ---------------- reset state ----------------
        tick(3);
        check_val("rst_busy", busy, 0);
        check_val("rst_starts", {init_start, shuf_start, dec_start}, 0);
        check_val("rst_status", {all_done, error, err_phase}, 0);
        check_val("rst_mem", {mem_address, mem_data, mem_wren}, 0);
        reset_n = 1'b1;
        tick(8);

        // ---------------- nominal run with isolation ----------------
        pulse_go();                                           // tick 0
        check_val("nom_t0_start", {init_start, shuf_start, dec_start}, 3'b100);
        check_val("nom_t0_busy", busy, 1);
        check_val("nom_t0_wren", mem_wren, 1);
        tick(5);                                              // tick 5
        check_val("nom_t5_addr", mem_address, 8'h05);
        check_val("nom_t5_data", mem_data, 8'h05);
        tick(251);                                            // tick 256
        check_val("nom_t256_init", init_start, 1);
        tick(1);                                              // tick 257: gap
        check_val("gap1_starts", {init_start, shuf_start, dec_start}, 0);
        check_val("gap1_busy", busy, 1);
        check_val("gap1_mem", {mem_address, mem_data, mem_wren}, 0);
        tick(1);                                              // tick 258
        check_val("shuf_t0_start", {init_start, shuf_start, dec_start}, 3'b010);
        check_val("shuf_t0_addr", mem_address, 8'h3C);
        check_val("shuf_t0_wren", mem_wren, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== 8'(i)) bad++;
        check_val("ram_fill_bad", bad, 0);
        tick(1);                                              // tick 259
        check_val("shuf_t1_addr", mem_address, 8'h3D);
        check_val("shuf_t1_data", mem_data, 8'h01);
        check_val("shuf_t1_wren", mem_wren, 1);
        tick(767);                                            // tick 1026: gap
        check_val("gap2_starts", {init_start, shuf_start, dec_start}, 0);
        check_val("gap2_busy", busy, 1);
        check_val("gap2_wren", mem_wren, 0);
        tick(1);                                              // tick 1027
        check_val("dec_t0_start", {init_start, shuf_start, dec_start}, 3'b001);
        tick(13);                                             // tick 1040
        pulse_go();                                           // tick 1041
        check_val("dec_go_ignored", {init_start, dec_start}, 2'b01);
        tick(49);                                             // tick 1090
        check_val("dec_last", {dec_start, all_done}, 2'b10);
        tick(1);                                              // tick 1091
        check_val("done_all", all_done, 1);
        check_val("done_busy", busy, 0);
        check_val("done_starts", {init_start, shuf_start, dec_start}, 0);
        check_val("done_err", {error, err_phase}, 0);
        check_val("done_wren", mem_wren, 0);
        check_val("onehot_viol", multi, 0);

        // ---------------- rerun from DONE with stale init_done ----------------
        stale_hold = 1'b1;
        stale_len  = 2;
        tick(2);
        pulse_go();                                           // tick 0
        stale_hold = 1'b0;
        check_val("rerun_t0", {init_start, all_done}, 2'b10);
        tick(2);                                              // tick 2
        check_val("stale_t2_init", init_start, 1);
        tick(1);                                              // tick 3
        check_val("stale_t3_init", init_start, 1);
        tick(254);                                            // tick 257
        check_val("stale_gap1", {init_start, shuf_start, busy}, 3'b001);
        tick(834);                                            // tick 1091
        check_val("rerun_done", all_done, 1);
        stale_len = 0;

        // ---------------- async reset mid-INIT ----------------
        tick(2);
        pulse_go();
        tick(128);                                            // tick 128
        check_val("mid_init_addr", mem_address, 8'h80);
        check_val("mid_init_wren", mem_wren, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_starts", {init_start, shuf_start, dec_start}, 0);
        check_val("arst_status", {busy, all_done, error}, 0);
        check_val("arst_mem", {mem_address, mem_data, mem_wren}, 0);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check_val("post_rst_idle", {busy, init_start, all_done}, 0);

        // ---------------- shuffle hang on TIMEOUT=64 instance ----------------
        use_t  = 1'b1;
        init_d = 10;
        shuf_d = 100000;
        tick(1);
        pulse_go();                                           // tick 0
        check_val("to_t0_init", t_init_start, 1);
        tick(10);                                             // tick 10: gap
        check_val("to_gap1", {t_init_start, t_shuf_start, t_busy}, 3'b001);
        tick(1);                                              // tick 11: SHUF entry
        check_val("to_shuf_start", t_shuf_start, 1);
        tick(63);                                             // tick 74
        check_val("to_t74", {t_shuf_start, t_error}, 2'b10);
        tick(1);                                              // tick 75
        check_val("to_error", t_error, 1);
        check_val("to_err_phase", t_err_phase, 2);
        check_val("to_starts", {t_init_start, t_shuf_start, t_dec_start, t_busy}, 0);
        check_val("to_wren", t_mem_wren, 0);
        tick(15);
        check_val("to_sticky", {t_error, t_err_phase}, 3'b110);
        pulse_go();
        check_val("to_restart", {t_init_start, t_error, t_err_phase}, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
